// File: rtl/motor_relu_stream_pipe.sv
// Two-stage streaming activation for packed fixed-point channels.
// The activation function (ReLU, leaky ReLU or clipped ReLU) is chosen at
// elaboration time. Stage 1 registers the input beat together with its
// per-channel sign and ceiling flags. Stage 2 registers the activated result,
// which drives out_data directly. A valid/ready handshake sustains one beat
// per cycle under backpressure. A saturating counter records how many beats
// had at least one channel clipped.
module motor_relu_stream_pipe #(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned W          = 18,
    parameter int unsigned I          = 7,
    parameter int unsigned MODE       = 0,
    parameter int unsigned LEAK_SHIFT = 3,
    parameter int unsigned CLIP_INT   = 6
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_CH*W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_CH*W-1:0] out_data,
    output logic [15:0]       clip_cnt,
    input  logic              clip_cnt_clr
);

    localparam int unsigned F       = W - I;
    localparam longint      CapL    = longint'(CLIP_INT) << F;
    localparam longint      MaxPosL = (longint'(1) << (W - 1)) - 1;
    localparam logic signed [W-1:0] Cap = CapL[W-1:0];

    // A clip ceiling that cannot be represented would silently wrap negative.
    if (CapL > MaxPosL) begin : gen_cap_range_check
        $error("motor_relu_stream_pipe: CLIP_INT << F exceeds the largest positive W-bit value");
    end

    if (MODE > 2) begin : gen_mode_check
        $error("motor_relu_stream_pipe: MODE must be 0, 1 or 2");
    end

    // Stage 1: registered input beat and per-channel classification flags.
    logic              v1_q, v1_d;
    logic [N_CH*W-1:0] x1_q, x1_d;
    logic [N_CH-1:0]   pos1_q, pos1_d;
    logic [N_CH-1:0]   neg1_q, neg1_d;
    logic [N_CH-1:0]   over1_q, over1_d;

    // Stage 2: activated result.
    logic              v2_q, v2_d;
    logic [N_CH*W-1:0] y2_q, y2_d;

    // Clip monitor.
    logic [15:0]       cnt_q, cnt_d;
    logic              clip_hit;

    // Stage enables.
    logic              e1, e2;

    // A stage may load when it is empty or when its contents move on this cycle.
    always_comb begin
        e2       = !v2_q || out_ready;
        e1       = !v1_q || e2;
        in_ready = e1;
    end

    // Stage 1 next state: capture the accepted beat and classify each channel.
    always_comb begin
        logic signed [W-1:0] x;
        x       = '0;
        v1_d    = v1_q;
        x1_d    = x1_q;
        pos1_d  = pos1_q;
        neg1_d  = neg1_q;
        over1_d = over1_q;
        if (e1) begin
            v1_d = in_valid;
            if (in_valid) begin
                x1_d = in_data;
                for (int k = 0; k < int'(N_CH); k++) begin
                    x          = $signed(in_data[k*W +: W]);
                    pos1_d[k]  = (x > 0);
                    neg1_d[k]  = (x < 0);
                    // The ceiling flag only has meaning for the clipped variant.
                    over1_d[k] = (MODE == 2) && (x > Cap);
                end
            end
        end
    end

    // Stage 2 next state: select the activated value per channel.
    always_comb begin
        logic signed [W-1:0] x;
        logic signed [W-1:0] y;
        x    = '0;
        y    = '0;
        v2_d = v2_q;
        y2_d = y2_q;
        if (e2) begin
            v2_d = v1_q;
            if (v1_q) begin
                for (int k = 0; k < int'(N_CH); k++) begin
                    x = $signed(x1_q[k*W +: W]);
                    case (MODE)
                        0: y = pos1_q[k] ? x : '0;
                        // Arithmetic shift floors toward minus infinity.
                        1: y = neg1_q[k] ? (x >>> LEAK_SHIFT) : x;
                        default: begin
                            if (!pos1_q[k]) begin
                                y = '0;
                            end else if (over1_q[k]) begin
                                y = Cap;
                            end else begin
                                y = x;
                            end
                        end
                    endcase
                    y2_d[k*W +: W] = y;
                end
            end
        end
    end

    // Clip counter next state: counts beats moving S1 to S2 with any channel over the ceiling.
    always_comb begin
        clip_hit = (MODE == 2) && v1_q && e2 && (|over1_q);
        cnt_d    = cnt_q;
        if (clip_cnt_clr) begin
            cnt_d = '0;
        end else if (clip_hit && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // State registers; reset discards all in-flight beats.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            v1_q    <= 1'b0;
            x1_q    <= '0;
            pos1_q  <= '0;
            neg1_q  <= '0;
            over1_q <= '0;
            v2_q    <= 1'b0;
            y2_q    <= '0;
            cnt_q   <= '0;
        end else begin
            v1_q    <= v1_d;
            x1_q    <= x1_d;
            pos1_q  <= pos1_d;
            neg1_q  <= neg1_d;
            over1_q <= over1_d;
            v2_q    <= v2_d;
            y2_q    <= y2_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs come straight from stage-2 and counter registers.
    always_comb begin
        out_valid = v2_q;
        out_data  = y2_q;
        clip_cnt  = cnt_q;
    end

endmodule
